// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper driver.
//   state_t          : controller states IDLE / MOVE / SETTLE
//   dir_t            : step direction
//   HALF_STEP_TABLE  : coil pattern {A,B,C,D} for each half-step phase 0..7
//   next_phase()     : phase advance modulo 8 in the given direction
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    // Element [0] is the last entry of the concatenation.
    localparam logic [7:0][3:0] HALF_STEP_TABLE = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    // 3-bit arithmetic gives the modulo-8 wrap for free.
    function automatic logic [2:0] next_phase(input logic [2:0] phase, input dir_t dir);
        return (dir == DIR_POS) ? phase + 3'd1 : phase - 3'd1;
    endfunction

endpackage

// File: rtl/stepper_tick_timer.sv
// Loadable down-counter shared by step spacing and settle timing.
//   clock, reset : clock and asynchronous active-high reset
//   load         : load load_value (highest priority)
//   clear        : force count to zero
//   run          : decrement while non-zero
//   load_value   : value taken on load
//   tc           : terminal count, high while the count is zero
module stepper_tick_timer #(
    parameter int W = 24
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic         run,
    input  logic [W-1:0] load_value,
    output logic         tc
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (clear) begin
            count_reg <= '0;
        end else if (run && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign tc = (count_reg == '0);

endmodule

// File: rtl/stepper_driver.sv
// Half-step unipolar stepper driver with hardware step timer.
// Software writes target and period and polls busy/done.
//   clock, reset : system clock, asynchronous active-high reset
//   enable       : 0 aborts motion and de-energises the coils
//   load         : 1-cycle strobe latching target and period
//   target       : signed absolute target position (half-steps)
//   period       : clock cycles between half-steps (clamped to MIN_PERIOD)
//   busy         : high in MOVE or SETTLE
//   done         : 1-cycle pulse when the settle hold expires
//   step_pulse   : 1-cycle pulse with every position update
//   position     : current signed position (half-steps)
//   coils        : coil drive {A,B,C,D}
module stepper_driver
    import stepper_pkg::*;
#(
    parameter int POS_W         = 16,
    parameter int PER_W         = 24,
    parameter int MIN_PERIOD    = 50000,
    parameter int SETTLE_CYCLES = 1000000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic signed [POS_W-1:0] target,
    input  logic        [PER_W-1:0] period,
    output logic                    busy,
    output logic                    done,
    output logic                    step_pulse,
    output logic signed [POS_W-1:0] position,
    output logic              [3:0] coils
);

    localparam logic [PER_W-1:0] MIN_PER       = PER_W'(MIN_PERIOD);
    localparam logic [PER_W-1:0] SETTLE_RELOAD = PER_W'(SETTLE_CYCLES - 1);

    state_t                    state_reg, state_next;
    logic signed [POS_W-1:0]   tgt_reg, tgt_next;
    logic signed [POS_W-1:0]   pos_reg, pos_next;
    logic        [PER_W-1:0]   per_reg, per_next;
    logic        [PER_W-1:0]   per_clamped;
    logic              [2:0]   phase_reg, phase_next;
    logic                      done_reg, done_next;
    logic                      step_reg, step_next;
    logic              [3:0]   coils_reg, coils_next;
    dir_t                      step_dir;

    logic                      timer_load;
    logic                      timer_clear;
    logic                      timer_run;
    logic        [PER_W-1:0]   timer_value;
    logic                      timer_tc;

    stepper_tick_timer #(
        .W (PER_W)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .clear      (timer_clear),
        .run        (timer_run),
        .load_value (timer_value),
        .tc         (timer_tc)
    );

    assign per_clamped = (period < MIN_PER) ? MIN_PER : period;
    assign step_dir    = (tgt_reg > pos_reg) ? DIR_POS : DIR_NEG;

    always_comb begin
        state_next  = state_reg;
        tgt_next    = tgt_reg;
        per_next    = per_reg;
        pos_next    = pos_reg;
        phase_next  = phase_reg;
        done_next   = 1'b0;
        step_next   = 1'b0;
        timer_load  = 1'b0;
        timer_clear = 1'b0;
        timer_run   = 1'b0;
        timer_value = '0;

        if (!enable) begin
            state_next  = IDLE;
            timer_clear = 1'b1;
        end else begin
            // A due step is taken even if a new command arrives this cycle,
            // so the retarget decision below sees the updated position.
            if ((state_reg == MOVE) && timer_tc) begin
                step_next  = 1'b1;
                phase_next = next_phase(phase_reg, step_dir);
                pos_next   = (step_dir == DIR_POS) ? pos_reg + POS_W'(1)
                                                   : pos_reg - POS_W'(1);
            end

            if (load) begin
                tgt_next   = target;
                per_next   = per_clamped;
                timer_load = 1'b1;
                if (target == pos_next) begin
                    state_next  = SETTLE;
                    timer_value = SETTLE_RELOAD;
                end else begin
                    state_next  = MOVE;
                    timer_value = per_clamped - PER_W'(1);
                end
            end else begin
                case (state_reg)
                    MOVE: begin
                        if (timer_tc) begin
                            timer_load = 1'b1;
                            if (pos_next == tgt_reg) begin
                                state_next  = SETTLE;
                                timer_value = SETTLE_RELOAD;
                            end else begin
                                timer_value = per_reg - PER_W'(1);
                            end
                        end else begin
                            timer_run = 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (timer_tc) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            timer_run = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Coil pattern follows the registered phase, so it lags a phase change by one cycle.
    for (genvar gi = 0; gi < 4; gi++) begin : g_coil
        assign coils_next[gi] = enable & HALF_STEP_TABLE[phase_reg][gi];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tgt_reg   <= '0;
            per_reg   <= '0;
            pos_reg   <= '0;
            phase_reg <= '0;
            done_reg  <= 1'b0;
            step_reg  <= 1'b0;
            coils_reg <= '0;
        end else begin
            tgt_reg   <= tgt_next;
            per_reg   <= per_next;
            pos_reg   <= pos_next;
            phase_reg <= phase_next;
            done_reg  <= done_next;
            step_reg  <= step_next;
            coils_reg <= coils_next;
        end
    end

    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign step_pulse = step_reg;
    assign position   = pos_reg;
    assign coils      = coils_reg;

endmodule

// File: tb/tb_stepper_driver.sv
// Directed bench for stepper_driver with MIN_PERIOD=4, SETTLE_CYCLES=8.
module tb_stepper_driver;

    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic               load;
    logic signed [15:0] target;
    logic        [23:0] period;
    logic               busy;
    logic               done;
    logic               step_pulse;
    logic signed [15:0] position;
    logic         [3:0] coils;

    int vectors     = 0;
    int miscompares = 0;
    int step_count  = 0;
    int done_count  = 0;
    int snap_step;
    int snap_done;

    stepper_driver #(
        .POS_W         (16),
        .PER_W         (24),
        .MIN_PERIOD    (4),
        .SETTLE_CYCLES (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .target     (target),
        .period     (period),
        .busy       (busy),
        .done       (done),
        .step_pulse (step_pulse),
        .position   (position),
        .coils      (coils)
    );

    always #5 clock = ~clock;

    // Pulse counters plus the done/step_pulse exclusivity check.
    always @(negedge clock) begin
        if (step_pulse) step_count++;
        if (done) done_count++;
        if (step_pulse || done) begin
            vectors++;
            assert (!(step_pulse && done)) else begin
                miscompares++;
                $error("FAIL excl: observed step_pulse=%0b done=%0b expected not both", step_pulse, done);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic do_load(input int tgt, input int per);
        target = 16'(tgt);
        period = 24'(per);
        load   = 1'b1;
        tick();
        load   = 1'b0;
        $display("load target=%0d period=%0d enable=%0b -> busy=%0b position=%0d",
                 tgt, per, enable, busy, position);
    endtask

    // Starts n_before cycles before the expected step edge; ends one cycle after it.
    task automatic expect_step(input int n_before, input int exp_pos, input logic [3:0] exp_coils,
                               input string tag);
        repeat (n_before - 1) tick();
        check({tag, ".early"}, step_pulse, 0);
        tick();
        check({tag, ".pulse"}, step_pulse, 1);
        check({tag, ".pos"}, position, exp_pos);
        tick();
        check({tag, ".coils"}, coils, exp_coils);
    endtask

    // Starts one cycle after entering SETTLE.
    task automatic finish_settle(input string tag);
        repeat (6) tick();
        check({tag, ".busy_hold"}, busy, 1);
        check({tag, ".done_early"}, done, 0);
        tick();
        check({tag, ".done"}, done, 1);
        check({tag, ".idle"}, busy, 0);
        tick();
        check({tag, ".done_1cyc"}, done, 0);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        load   = 1'b0;
        target = '0;
        period = '0;
        repeat (2) tick();
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.step", step_pulse, 0);
        check("rst.pos", position, 0);
        check("rst.coils", coils, 4'b0000);
        reset = 1'b0;
        tick();
        check("idle.coils", coils, 4'b1000);

        // +3 at period 10
        do_load(3, 10);
        check("t1.busy", busy, 1);
        expect_step(10, 1, 4'b1100, "t1.s1");
        expect_step(9, 2, 4'b0100, "t1.s2");
        expect_step(9, 3, 4'b0110, "t1.s3");
        finish_settle("t1");

        // to -2 with period 0 -> clamped to 4
        do_load(-2, 0);
        expect_step(4, 2, 4'b0100, "t2.s1");
        expect_step(3, 1, 4'b1100, "t2.s2");
        expect_step(3, 0, 4'b1000, "t2.s3");
        expect_step(3, -1, 4'b1001, "t2.s4");
        expect_step(3, -2, 4'b0001, "t2.s5");
        finish_settle("t2");

        // target equal to position: settle only
        snap_step = step_count;
        snap_done = done_count;
        do_load(-2, 10);
        check("t3.busy", busy, 1);
        tick();
        finish_settle("t3");
        check("t3.nostep", step_count - snap_step, 0);
        check("t3.onedone", done_count - snap_done, 1);

        // retarget mid-move
        snap_done = done_count;
        do_load(10, 6);
        expect_step(6, -1, 4'b1001, "t4.s1");
        expect_step(5, 0, 4'b1000, "t4.s2");
        expect_step(5, 1, 4'b1100, "t4.s3");
        expect_step(5, 2, 4'b0100, "t4.s4");
        expect_step(5, 3, 4'b0110, "t4.s5");
        expect_step(5, 4, 4'b0010, "t4.s6");
        do_load(1, 6);
        expect_step(6, 3, 4'b0110, "t4.r1");
        expect_step(5, 2, 4'b0100, "t4.r2");
        expect_step(5, 1, 4'b1100, "t4.r3");
        finish_settle("t4");
        repeat (3) tick();
        check("t4.onedone", done_count - snap_done, 1);
        check("t4.final_pos", position, 1);

        // enable drop mid-move
        do_load(10, 4);
        expect_step(4, 2, 4'b0100, "t5.s1");
        expect_step(3, 3, 4'b0110, "t5.s2");
        expect_step(3, 4, 4'b0010, "t5.s3");
        expect_step(3, 5, 4'b0011, "t5.s4");
        snap_step = step_count;
        snap_done = done_count;
        enable = 1'b0;
        tick();
        check("t5.coils_off", coils, 4'b0000);
        check("t5.busy_off", busy, 0);
        check("t5.pos_hold", position, 5);
        do_load(-5, 4);
        check("t5.load_ignored", busy, 0);
        repeat (10) tick();
        check("t5.still_idle", busy, 0);
        check("t5.pos_still", position, 5);
        check("t5.nostep", step_count - snap_step, 0);
        check("t5.nodone", done_count - snap_done, 0);
        enable = 1'b1;
        tick();
        check("t5.coils_back", coils, 4'b0011);
        check("t5.busy_back", busy, 0);

        // asynchronous reset mid-move, right after a step
        do_load(8, 4);
        expect_step(4, 6, 4'b0001, "t6.s1");
        repeat (2) tick();
        tick();
        check("t6.pulse", step_pulse, 1);
        check("t6.pos", position, 7);
        #2 reset = 1'b1;
        #1;
        check("t6.rst_busy", busy, 0);
        check("t6.rst_done", done, 0);
        check("t6.rst_step", step_pulse, 0);
        check("t6.rst_pos", position, 0);
        check("t6.rst_coils", coils, 4'b0000);
        tick();
        reset = 1'b0;
        snap_step = step_count;
        repeat (12) tick();
        check("t6.idle_busy", busy, 0);
        check("t6.idle_pos", position, 0);
        check("t6.idle_coils", coils, 4'b1000);
        check("t6.idle_nostep", step_count - snap_step, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
